// File: rtl/vector_lsu_pkg.sv
// Shared types and sizing for the vector load/store unit.
// The request struct is used for both element requests and memory responses.
package vector_lsu_pkg;

  localparam int ADDR_WIDTH        = 64;
  localparam int VECTOR_REG_WIDTH  = 64;
  localparam int VECTOR_REG_DEPTH  = 64;
  localparam int NUM_OF_VECTOR_REG = 8;

  localparam int TAG_W  = $clog2(VECTOR_REG_DEPTH);
  localparam int VREG_W = $clog2(NUM_OF_VECTOR_REG);
  localparam int VLEN_W = TAG_W + 1;
  localparam int CNT_W  = 7;

  typedef struct packed {
    logic                        vld;
    logic                        we;
    logic [ADDR_WIDTH-1:0]       addr;
    logic [VECTOR_REG_WIDTH-1:0] data;
    logic [TAG_W-1:0]            tag;
  } request_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } lsu_state_e;

  // A zero element count is illegal and is promoted to a full register.
  function automatic logic [VLEN_W-1:0] eff_vlen(input logic [VLEN_W-1:0] v);
    return (v == '0) ? VLEN_W'(VECTOR_REG_DEPTH) : v;
  endfunction

endpackage

// File: rtl/vector_lsu_if.sv
// Command, memory, vector-register and write-back signals of the LSU.
// master is the LSU side; slave is the surrounding core/memory side.
interface vector_lsu_if;
  import vector_lsu_pkg::*;

  logic                        cmd_vld;
  logic                        cmd_rdy;
  logic                        cmd_is_store;
  logic [VREG_W-1:0]           cmd_vreg;
  logic [ADDR_WIDTH-1:0]       cmd_base;
  logic [ADDR_WIDTH-1:0]       cmd_stride;
  logic [VLEN_W-1:0]           cmd_vlen;
  request_t                    mem_req;
  logic                        mem_req_rdy;
  request_t                    mem_rsp;
  logic [VREG_W-1:0]           st_rd_vreg;
  logic [TAG_W-1:0]            st_rd_addr;
  logic [VECTOR_REG_WIDTH-1:0] st_rd_data;
  logic                        wb_vld;
  logic [VREG_W-1:0]           wb_vreg;
  logic [TAG_W-1:0]            wb_addr;
  logic [VECTOR_REG_WIDTH-1:0] wb_data;
  logic                        done;
  logic                        err;

  modport master (
    input  cmd_vld, cmd_is_store, cmd_vreg, cmd_base, cmd_stride, cmd_vlen,
           mem_req_rdy, mem_rsp, st_rd_data,
    output cmd_rdy, mem_req, st_rd_vreg, st_rd_addr,
           wb_vld, wb_vreg, wb_addr, wb_data, done, err
  );

  modport slave (
    output cmd_vld, cmd_is_store, cmd_vreg, cmd_base, cmd_stride, cmd_vlen,
           mem_req_rdy, mem_rsp, st_rd_data,
    input  cmd_rdy, mem_req, st_rd_vreg, st_rd_addr,
           wb_vld, wb_vreg, wb_addr, wb_data, done, err
  );
endinterface

// File: rtl/vector_lsu_tag_tracker.sv
// Pending-tag bitmap and outstanding-request counter for the LSU.
// hit reflects the bitmap before this cycle's set, so a tag issued now cannot retire now.
module lsu_tag_tracker
  import vector_lsu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             rsp_vld,
  input  logic [TAG_W-1:0] rsp_tag,
  output logic             hit,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next
);

  logic [VECTOR_REG_DEPTH-1:0] pending;

  assign hit = rsp_vld && pending[rsp_tag];

  always_comb begin
    count_next = count;
    case ({set_en, hit})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      count   <= '0;
    end else begin
      if (hit)    pending[rsp_tag] <= 1'b0;
      if (set_en) pending[set_tag] <= 1'b1;
      count <= count_next;
    end
  end

endmodule

// File: rtl/vector_lsu.sv
// Strided vector load/store unit: splits one command into per-element requests,
// retires responses by tag and writes load data back to the vector register file.
module vector_lsu
  import vector_lsu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  vector_lsu_if.master bus
);

  lsu_state_e            state;
  logic                  is_store;
  logic [VREG_W-1:0]     vreg;
  logic [VLEN_W-1:0]     vlen;
  logic [VLEN_W-1:0]     idx;
  logic [ADDR_WIDTH-1:0] addr_run;
  logic [ADDR_WIDTH-1:0] stride;
  logic                  done_q;
  logic                  err_q;

  logic                        wb_vld_p1;
  logic [VREG_W-1:0]           wb_vreg_p1;
  logic [TAG_W-1:0]            wb_addr_p1;
  logic [VECTOR_REG_WIDTH-1:0] wb_data_p1;

  logic             issuing, fire, last, hit;
  logic [CNT_W-1:0] count, count_next;
  logic             unused_rsp;

  assign issuing    = (state == ISSUE);
  assign fire       = issuing && bus.mem_req_rdy;
  assign last       = (idx == vlen - VLEN_W'(1));
  assign unused_rsp = ^{bus.mem_rsp.we, bus.mem_rsp.addr};

  lsu_tag_tracker u_trk (
    .clk        (clk),
    .reset      (reset),
    .set_en     (fire),
    .set_tag    (idx[TAG_W-1:0]),
    .rsp_vld    (bus.mem_rsp.vld),
    .rsp_tag    (bus.mem_rsp.tag),
    .hit        (hit),
    .count      (count),
    .count_next (count_next)
  );

  // Request fields come straight from registered state, so they hold under backpressure.
  always_comb begin
    bus.mem_req = '0;
    if (issuing) begin
      bus.mem_req.vld  = 1'b1;
      bus.mem_req.we   = is_store;
      bus.mem_req.addr = addr_run;
      bus.mem_req.tag  = idx[TAG_W-1:0];
      bus.mem_req.data = is_store ? bus.st_rd_data : '0;
    end
  end

  assign bus.cmd_rdy    = (state == IDLE);
  assign bus.st_rd_vreg = vreg;
  assign bus.st_rd_addr = idx[TAG_W-1:0];
  assign bus.wb_vld     = wb_vld_p1;
  assign bus.wb_vreg    = wb_vreg_p1;
  assign bus.wb_addr    = wb_addr_p1;
  assign bus.wb_data    = wb_data_p1;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      is_store   <= 1'b0;
      vreg       <= '0;
      vlen       <= '0;
      idx        <= '0;
      addr_run   <= '0;
      stride     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wb_vld_p1  <= 1'b0;
      wb_vreg_p1 <= '0;
      wb_addr_p1 <= '0;
      wb_data_p1 <= '0;
    end else begin
      done_q <= 1'b0;
      // stage p1: registered write-back of a retired load response
      wb_vld_p1 <= hit && !is_store;
      if (hit) begin
        wb_vreg_p1 <= vreg;
        wb_addr_p1 <= bus.mem_rsp.tag;
        wb_data_p1 <= bus.mem_rsp.data;
      end
      if (bus.mem_rsp.vld && !hit) err_q <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.cmd_vld) begin
            is_store <= bus.cmd_is_store;
            vreg     <= bus.cmd_vreg;
            vlen     <= eff_vlen(bus.cmd_vlen);
            stride   <= bus.cmd_stride;
            addr_run <= bus.cmd_base;
            idx      <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (fire) begin
            idx      <= idx + VLEN_W'(1);
            addr_run <= addr_run + stride;
            if (last) state <= DRAIN;
          end
        end
        DRAIN: begin
          // done is raised as the last response retires; IDLE follows one cycle later.
          if (done_q)                 state  <= IDLE;
          else if (count_next == '0)  done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_lsu.sv
// Scoreboard bench for vector_lsu: reference requests and write-backs are queued by
// the stimulus side and consumed by a monitor that samples on the falling edge.
module tb_vector_lsu;
  import vector_lsu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vector_lsu_if bus();
  vector_lsu dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [63:0] addr; logic we; logic [63:0] data; logic [5:0] tag; } ereq_t;
  typedef struct { logic [2:0] vreg; logic [5:0] addr; logic [63:0] data; } ewb_t;

  int n_cmp = 0;
  int n_bad = 0;

  ereq_t exp_req[$];
  ewb_t  exp_wb[$];
  int    accepted[$];
  int    inject[$];
  bit    model_pend[64];
  int    model_out = 0;
  logic  model_err = 1'b0;

  int   hs_cnt = 0, rsp_cnt = 0, cur_vl = 0, last_rsp_cyc = 0, cyc = 0;
  int   done_seen = 0, wb_cnt = 0, peak = 0;
  logic cur_store = 1'b0;
  logic [2:0] cur_vreg = '0;
  int   rsp_mode = 0, rdy_mode = 0, bp_at = -1, bp_left = 0;
  logic rev_go = 1'b0;
  logic stall_prev = 1'b0, done_prev = 1'b0;
  request_t stall_req;

  logic [63:0] vregs [8][64];
  assign bus.st_rd_data = vregs[bus.st_rd_vreg][bus.st_rd_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    ereq_t e;
    ewb_t  w;
    int    ntag;
    logic  nnew;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_prev = 1'b0;
        done_prev  = 1'b0;
      end else begin
        cyc++;
        chk("outstanding", 64'(dut.u_trk.count), 64'(model_out));
        if (int'(dut.u_trk.count) > peak) peak = int'(dut.u_trk.count);
        chk("err_flag", 64'(bus.err), 64'(model_err));

        if (bus.wb_vld) begin
          wb_cnt++;
          if (exp_wb.size() == 0) chk("wb_unexpected", 64'd1, 64'd0);
          else begin
            w = exp_wb.pop_front();
            chk("wb_addr", 64'(bus.wb_addr), 64'(w.addr));
            chk("wb_data", bus.wb_data, w.data);
            chk("wb_vreg", 64'(bus.wb_vreg), 64'(w.vreg));
          end
        end

        if (done_prev) chk("rdy_after_done", 64'(bus.cmd_rdy), 64'd1);
        done_prev = bus.done;
        if (bus.done) begin
          done_seen++;
          chk("done_cmd_rdy", 64'(bus.cmd_rdy), 64'd0);
          chk("done_outstanding", 64'(model_out), 64'd0);
          chk("done_rsp_count", 64'(rsp_cnt), 64'(cur_vl));
          chk("done_latency", 64'(cyc), 64'(last_rsp_cyc + 1));
          chk("done_wb_left", 64'(exp_wb.size()), 64'd0);
        end

        if (stall_prev && bus.mem_req.vld)
          chk("req_stable", 64'(bus.mem_req == stall_req), 64'd1);
        stall_prev = bus.mem_req.vld && !bus.mem_req_rdy;
        stall_req  = bus.mem_req;

        nnew = 1'b0;
        ntag = 0;
        if (bus.mem_req.vld && bus.mem_req_rdy) begin
          if (exp_req.size() == 0) chk("req_unexpected", 64'd1, 64'd0);
          else begin
            e = exp_req.pop_front();
            chk("req_addr", bus.mem_req.addr, e.addr);
            chk("req_tag", 64'(bus.mem_req.tag), 64'(e.tag));
            chk("req_we", 64'(bus.mem_req.we), 64'(e.we));
            if (e.we) chk("req_data", bus.mem_req.data, e.data);
          end
          hs_cnt++;
          ntag = int'(bus.mem_req.tag);
          nnew = 1'b1;
        end

        if (bus.mem_rsp.vld) begin
          if (model_pend[bus.mem_rsp.tag]) begin
            model_pend[bus.mem_rsp.tag] = 1'b0;
            model_out--;
            rsp_cnt++;
            last_rsp_cyc = cyc;
            if (!cur_store) begin
              w.vreg = cur_vreg; w.addr = bus.mem_rsp.tag; w.data = bus.mem_rsp.data;
              exp_wb.push_back(w);
            end
          end else begin
            model_err = 1'b1;
          end
        end

        if (nnew) begin
          model_pend[ntag] = 1'b1;
          model_out++;
          accepted.push_back(ntag);
        end
      end
    end
  end

  // Memory side: ready pattern and responses
  initial begin : responder
    request_t r;
    int k;
    bus.mem_req_rdy = 1'b0;
    bus.mem_rsp     = '0;
    forever begin
      @(posedge clk); #1;
      if (bp_left > 0) begin
        bus.mem_req_rdy = 1'b0;
        bp_left--;
      end else if (bp_at >= 0 && hs_cnt == bp_at) begin
        bus.mem_req_rdy = 1'b0;
        bp_left = 4;
        bp_at = -1;
      end else begin
        bus.mem_req_rdy = (rdy_mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
      end
      r = '0;
      if (inject.size() != 0) begin
        r.vld = 1'b1;
        r.tag = 6'(inject.pop_front());
      end else if (accepted.size() != 0) begin
        case (rsp_mode)
          0: begin r.vld = 1'b1; r.tag = 6'(accepted.pop_front()); end
          1: if ($urandom_range(2) != 0) begin
               k = $urandom_range(accepted.size() - 1);
               r.vld = 1'b1; r.tag = 6'(accepted[k]);
               accepted.delete(k);
             end
          2: begin
               if (accepted.size() == cur_vl) rev_go = 1'b1;
               if (rev_go) begin r.vld = 1'b1; r.tag = 6'(accepted.pop_back()); end
             end
          default: ;
        endcase
      end
      if (r.vld) r.data = {$urandom, $urandom};
      bus.mem_rsp = r;
    end
  end

  task automatic start_cmd(input logic st, input logic [2:0] vr, input logic [63:0] base,
                           input logic [63:0] stride, input logic [6:0] vlen,
                           input int rspm, input int rdym, input int bpa);
    int vl, g;
    ereq_t e;
    vl = (vlen == 0) ? 64 : int'(vlen);
    g = 0;
    @(negedge clk); #1;
    while (!bus.cmd_rdy && g < 200) begin @(negedge clk); #1; g++; end
    chk("cmd_rdy_wait", 64'(bus.cmd_rdy), 64'd1);
    @(posedge clk); #2;
    for (int i = 0; i < vl; i++) begin
      e.addr = base + stride * 64'(i);
      e.we   = st;
      e.data = st ? vregs[vr][i] : 64'd0;
      e.tag  = 6'(i);
      exp_req.push_back(e);
    end
    cur_vl = vl; cur_store = st; cur_vreg = vr; rsp_cnt = 0; hs_cnt = 0; rev_go = 1'b0;
    peak = 0; rsp_mode = rspm; rdy_mode = rdym; bp_at = bpa;
    bus.cmd_vld = 1'b1; bus.cmd_is_store = st; bus.cmd_vreg = vr;
    bus.cmd_base = base; bus.cmd_stride = stride; bus.cmd_vlen = vlen;
    @(posedge clk); #2;
    bus.cmd_vld = 1'b0;
    @(negedge clk); #1;
    chk("first_req_vld", 64'(bus.mem_req.vld), 64'd1);
  endtask

  task automatic run_cmd(input logic st, input logic [2:0] vr, input logic [63:0] base,
                         input logic [63:0] stride, input logic [6:0] vlen,
                         input int rspm, input int rdym, input int bpa);
    int d0, g;
    d0 = done_seen;
    start_cmd(st, vr, base, stride, vlen, rspm, rdym, bpa);
    g = 0;
    while (done_seen == d0 && g < 3000) begin @(negedge clk); #1; g++; end
    chk("done_arrived", 64'(done_seen - d0), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("done_once", 64'(done_seen - d0), 64'd1);
    chk("req_drained", 64'(exp_req.size()), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int g, w0;
    for (int v = 0; v < 8; v++)
      for (int i = 0; i < 64; i++) vregs[v][i] = {$urandom, $urandom};
    vregs[2][0] = 64'hAAAA_AAAA_0000_000A;
    vregs[2][1] = 64'hBBBB_BBBB_0000_000B;
    vregs[2][2] = 64'hCCCC_CCCC_0000_000C;
    bus.cmd_vld = 1'b0; bus.cmd_is_store = 1'b0; bus.cmd_vreg = '0;
    bus.cmd_base = '0; bus.cmd_stride = '0; bus.cmd_vlen = '0;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_rdy", 64'(bus.cmd_rdy), 64'd1);
    chk("rst_mem_req", 64'(bus.mem_req == '0), 64'd1);
    chk("rst_wb_vld", 64'(bus.wb_vld), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    @(posedge clk); #2;
    reset = 1'b1;

    // directed scenarios
    run_cmd(1'b0, 3'd1, 64'h1000, 64'd8, 7'd4, 0, 0, -1);
    run_cmd(1'b1, 3'd2, 64'h100, -64'sd16, 7'd3, 0, 0, -1);
    run_cmd(1'b1, 3'd3, 64'h4000, 64'd24, 7'd12, 1, 0, 4);
    run_cmd(1'b0, 3'd5, 64'h2_0000, 64'd8, 7'd64, 2, 0, -1);
    chk("peak_outstanding", 64'(peak), 64'd64);

    w0 = wb_cnt;
    inject.push_back(5);
    repeat (3) @(negedge clk);
    #1;
    chk("stray_err", 64'(bus.err), 64'd1);
    chk("stray_no_wb", 64'(wb_cnt - w0), 64'd0);

    // randomized commands
    for (int n = 0; n < 6; n++) begin
      logic [6:0]  vl7;
      logic [63:0] strd;
      vl7  = (n == 2) ? 7'd0 : 7'($urandom_range(64, 1));
      strd = (n % 2 == 1) ? {$urandom, $urandom} : 64'($urandom_range(64)) * 64'd8;
      run_cmd(1'($urandom_range(1)), 3'($urandom_range(7)), {$urandom, $urandom}, strd, vl7,
              $urandom_range(2), $urandom_range(1), -1);
    end

    // reset while issuing element 7 of 16, no responses
    start_cmd(1'b0, 3'd4, 64'h8000, 64'd8, 7'd16, 3, 0, -1);
    g = 0;
    while (hs_cnt < 8 && g < 200) begin @(negedge clk); #1; g++; end
    chk("reached_idx7", 64'(hs_cnt), 64'd8);
    reset = 1'b0;
    #1;
    chk("midrst_cmd_rdy", 64'(bus.cmd_rdy), 64'd1);
    chk("midrst_mem_req", 64'(bus.mem_req == '0), 64'd1);
    chk("midrst_wb_vld", 64'(bus.wb_vld), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_err", 64'(bus.err), 64'd0);
    chk("midrst_count", 64'(dut.u_trk.count), 64'd0);
    exp_req.delete(); exp_wb.delete(); accepted.delete();
    for (int i = 0; i < 64; i++) model_pend[i] = 1'b0;
    model_out = 0; model_err = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_cmd_rdy", 64'(bus.cmd_rdy), 64'd1);
    chk("post_rst_req_vld", 64'(bus.mem_req.vld), 64'd0);

    run_cmd(1'b0, 3'd6, 64'h300, 64'd16, 7'd5, 0, 0, -1);
    inject.push_back(3);
    repeat (3) @(negedge clk);
    #1;
    chk("late_rsp_err", 64'(bus.err), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
